tlcd_bus_monitor: RTL and testbench

Receive-side decoder for the HD44780-style Text LCD bus driven by `TextLCD_Controller`. It samples `TLCD_E/RS/RW/D`, decodes instruction and data writes, and rebuilds the two 16-character display lines into `line1`/`line2`. Those lines use the same 128-bit packing that `LCD_Display` produces, so a bench or on-chip checker can compare what was sent with what was displayed. It sits beside the LCD pins, in parallel with the physical module, and never drives the bus.

---
 rtl/tlcd_pkg.sv | 71 +++++++
 rtl/tlcd_bus_sampler.sv | 92 +++++++++
 rtl/tlcd_bus_monitor.sv | 192 +++++++++++++++++++
 tb/tb_tlcd_bus_monitor.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlcd_pkg.sv
// Shared constants and helpers for the HD44780-style text LCD bus monitor.
// Optional 4-bit bus support is enabled with TLCD_MON_4BIT_EN.
package tlcd_pkg;

   // Instruction opcodes double as masks: the highest set bit selects the command
   localparam logic [7:0] OP_SET_DDRAM = 8'h80;
   localparam logic [7:0] OP_SET_CGRAM = 8'h40;
   localparam logic [7:0] OP_FUNC_SET  = 8'h20;
   localparam logic [7:0] OP_SHIFT     = 8'h10;
   localparam logic [7:0] OP_DISP_CTRL = 8'h08;
   localparam logic [7:0] OP_ENTRY     = 8'h04;
   localparam logic [7:0] OP_HOME      = 8'h02;
   localparam logic [7:0] OP_CLEAR     = 8'h01;

   localparam int BIT_DL = 4;
   localparam int BIT_N  = 3;
   localparam int BIT_SC = 3;
   localparam int BIT_RL = 2;
   localparam int BIT_D  = 2;
   localparam int BIT_ID = 1;
   localparam int BIT_S  = 0;

   localparam logic [6:0] LINE1_BASE = 7'h00;
   localparam logic [6:0] LINE2_BASE = 7'h40;
   localparam logic [6:0] LINE1_LAST = 7'h27;
   localparam logic [6:0] LINE2_LAST = 7'h67;

   localparam logic [7:0] SPACE_CHAR = 8'h20;

   typedef enum logic [3:0] {
      CMD_NOP,
      CMD_CLEAR,
      CMD_HOME,
      CMD_ENTRY,
      CMD_DISP_CTRL,
      CMD_SHIFT,
      CMD_FUNC_SET,
      CMD_SET_CGRAM,
      CMD_SET_DDRAM
   } cmd_e;

   function automatic cmd_e decode_cmd(input logic [7:0] b);
      if      (|(b & OP_SET_DDRAM)) return CMD_SET_DDRAM;
      else if (|(b & OP_SET_CGRAM)) return CMD_SET_CGRAM;
      else if (|(b & OP_FUNC_SET))  return CMD_FUNC_SET;
      else if (|(b & OP_SHIFT))     return CMD_SHIFT;
      else if (|(b & OP_DISP_CTRL)) return CMD_DISP_CTRL;
      else if (|(b & OP_ENTRY))     return CMD_ENTRY;
      else if (|(b & OP_HOME))      return CMD_HOME;
      else if (|(b & OP_CLEAR))     return CMD_CLEAR;
      else                          return CMD_NOP;
   endfunction

   // Gap addresses are accepted but step by plain +1/-1 until a legal value
   function automatic logic [6:0] next_ddram_addr(input logic [6:0] addr, input logic inc);
      if (inc) begin
         if (addr == LINE1_LAST)      return LINE2_BASE;
         else if (addr == LINE2_LAST) return LINE1_BASE;
         else                         return addr + 7'd1;
      end else begin
         if (addr == LINE1_BASE)      return LINE2_LAST;
         else if (addr == LINE2_BASE) return LINE1_LAST;
         else                         return addr - 7'd1;
      end
   endfunction

   function automatic logic is_gap_addr(input logic [6:0] addr);
      return ((addr > LINE1_LAST) && (addr < LINE2_BASE)) || (addr > LINE2_LAST);
   endfunction

endpackage

// File: rtl/tlcd_bus_sampler.sv
// Registers the LCD bus pins and turns each falling edge of E into one write
// transfer; with TLCD_MON_4BIT_EN it also pairs nibbles into bytes.
module tlcd_bus_sampler
   import tlcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] TLCD_D,
   input  logic       TLCD_E,
   input  logic       TLCD_RS,
   input  logic       TLCD_RW,
`ifdef TLCD_MON_4BIT_EN
   input  logic       mode4_i,
   output logic       xfer_err,
`endif
   output logic       xfer_valid,
   output logic       xfer_rs,
   output logic [7:0] xfer_byte
);

   logic       e_q;
   logic [7:0] d_q;
   logic       rs_q;
   logic       rw_q;
   logic       fall;

   always_ff @(posedge clk) begin
      if (rst) begin
         e_q  <= 1'b0;
         d_q  <= 8'h00;
         rs_q <= 1'b0;
         rw_q <= 1'b0;
      end else begin
         e_q  <= TLCD_E;
         d_q  <= TLCD_D;
         rs_q <= TLCD_RS;
         rw_q <= TLCD_RW;
      end
   end

   // Reads are dropped here so they cannot disturb nibble pairing either
   assign fall = e_q && !TLCD_E && !rw_q;

`ifdef TLCD_MON_4BIT_EN
   logic       phase_q, phase_d;
   logic [3:0] hi_q, hi_d;
   logic       hi_rs_q, hi_rs_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= 1'b0;
         hi_q    <= 4'h0;
         hi_rs_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
         hi_q    <= hi_d;
         hi_rs_q <= hi_rs_d;
      end
   end

   always_comb begin
      phase_d    = phase_q;
      hi_d       = hi_q;
      hi_rs_d    = hi_rs_q;
      xfer_valid = 1'b0;
      xfer_err   = 1'b0;
      xfer_rs    = rs_q;
      xfer_byte  = d_q;
      if (fall) begin
         if (!mode4_i) begin
            xfer_valid = 1'b1;
         end else if (!phase_q) begin
            phase_d = 1'b1;
            hi_d    = d_q[7:4];
            hi_rs_d = rs_q;
         end else begin
            phase_d   = 1'b0;
            xfer_byte = {hi_q, d_q[7:4]};
            if (hi_rs_q == rs_q) xfer_valid = 1'b1;
            else                 xfer_err   = 1'b1;
         end
      end
   end
`else
   always_comb begin
      xfer_valid = fall;
      xfer_rs    = rs_q;
      xfer_byte  = d_q;
   end
`endif

endmodule

// File: rtl/tlcd_bus_monitor.sv
// Passive HD44780 bus decoder rebuilding both display lines from observed writes.
// Define TLCD_MON_4BIT_EN to follow the controller into 4-bit bus mode.
module tlcd_bus_monitor #(
   parameter int         LINE_CHARS = 16,
   parameter logic [7:0] SPACE_CHAR = tlcd_pkg::SPACE_CHAR
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              TLCD_D,
   input  logic                    TLCD_E,
   input  logic                    TLCD_RS,
   input  logic                    TLCD_RW,
   output logic [8*LINE_CHARS-1:0] line1,
   output logic [8*LINE_CHARS-1:0] line2,
   output logic [6:0]              cursor_addr,
   output logic                    display_on,
   output logic                    cmd_strobe,
   output logic                    data_strobe,
   output logic                    proto_err
);
   import tlcd_pkg::*;

   localparam int         IDX_W = $clog2(LINE_CHARS);
   localparam logic [6:0] LC7   = 7'(LINE_CHARS);

   logic             xfer_valid;
   logic             xfer_rs;
   logic [7:0]       xfer_byte;

   logic [6:0]       addr_q, addr_d;
   logic             inc_q, inc_d;
   logic             disp_q, disp_d;
   logic             cgram_q, cgram_d;
   logic             err_q, err_d;
   logic             cmd_stb_q, cmd_stb_d;
   logic             data_stb_q, data_stb_d;

   logic             clear_lines;
   logic             wr_line1;
   logic             wr_line2;
   logic [IDX_W-1:0] wr_idx;
   logic [6:0]       off1;
   logic [6:0]       off2;

`ifdef TLCD_MON_4BIT_EN
   logic             xfer_err;
   logic             mode4_q, mode4_d;
`endif

   tlcd_bus_sampler u_sampler (
      .clk        (clk),
      .rst        (rst),
      .TLCD_D     (TLCD_D),
      .TLCD_E     (TLCD_E),
      .TLCD_RS    (TLCD_RS),
      .TLCD_RW    (TLCD_RW),
`ifdef TLCD_MON_4BIT_EN
      .mode4_i    (mode4_q),
      .xfer_err   (xfer_err),
`endif
      .xfer_valid (xfer_valid),
      .xfer_rs    (xfer_rs),
      .xfer_byte  (xfer_byte)
   );

   assign off1 = addr_q - LINE1_BASE;
   assign off2 = addr_q - LINE2_BASE;

   always_comb begin
      addr_d      = addr_q;
      inc_d       = inc_q;
      disp_d      = disp_q;
      cgram_d     = cgram_q;
      err_d       = err_q;
      cmd_stb_d   = 1'b0;
      data_stb_d  = 1'b0;
      clear_lines = 1'b0;
      wr_line1    = 1'b0;
      wr_line2    = 1'b0;
      wr_idx      = '0;
`ifdef TLCD_MON_4BIT_EN
      mode4_d     = mode4_q;
      if (xfer_err) err_d = 1'b1;
`endif
      if (xfer_valid) begin
         if (xfer_rs) begin
            data_stb_d = 1'b1;
            // CGRAM writes target glyph memory, which is not modelled
            if (!cgram_q) begin
               if (off1 < LC7) begin
                  wr_line1 = 1'b1;
                  wr_idx   = off1[IDX_W-1:0];
               end else if (off2 < LC7) begin
                  wr_line2 = 1'b1;
                  wr_idx   = off2[IDX_W-1:0];
               end
               addr_d = next_ddram_addr(addr_q, inc_q);
            end
         end else begin
            cmd_stb_d = 1'b1;
            case (decode_cmd(xfer_byte))
               CMD_SET_DDRAM: begin
                  addr_d  = xfer_byte[6:0];
                  cgram_d = 1'b0;
                  if (is_gap_addr(xfer_byte[6:0])) err_d = 1'b1;
               end
               CMD_SET_CGRAM: cgram_d = 1'b1;
               CMD_FUNC_SET: begin
                  if (!xfer_byte[BIT_N]) err_d = 1'b1;
`ifdef TLCD_MON_4BIT_EN
                  mode4_d = !xfer_byte[BIT_DL];
`else
                  if (!xfer_byte[BIT_DL]) err_d = 1'b1;
`endif
               end
               CMD_SHIFT: begin
                  if (xfer_byte[BIT_SC]) err_d  = 1'b1;
                  else                   addr_d = next_ddram_addr(addr_q, xfer_byte[BIT_RL]);
               end
               CMD_DISP_CTRL: disp_d = xfer_byte[BIT_D];
               CMD_ENTRY: begin
                  inc_d = xfer_byte[BIT_ID];
                  if (xfer_byte[BIT_S]) err_d = 1'b1;
               end
               CMD_HOME: begin
                  addr_d  = 7'h00;
                  cgram_d = 1'b0;
               end
               CMD_CLEAR: begin
                  clear_lines = 1'b1;
                  addr_d      = 7'h00;
                  inc_d       = 1'b1;
                  cgram_d     = 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q     <= 7'h00;
         inc_q      <= 1'b1;
         disp_q     <= 1'b0;
         cgram_q    <= 1'b0;
         err_q      <= 1'b0;
         cmd_stb_q  <= 1'b0;
         data_stb_q <= 1'b0;
`ifdef TLCD_MON_4BIT_EN
         mode4_q    <= 1'b0;
`endif
      end else begin
         addr_q     <= addr_d;
         inc_q      <= inc_d;
         disp_q     <= disp_d;
         cgram_q    <= cgram_d;
         err_q      <= err_d;
         cmd_stb_q  <= cmd_stb_d;
         data_stb_q <= data_stb_d;
`ifdef TLCD_MON_4BIT_EN
         mode4_q    <= mode4_d;
`endif
      end
   end

   // One register pair per character; char 0 sits in the top byte of each line
   for (genvar gi = 0; gi < LINE_CHARS; gi++) begin : g_char
      logic [7:0] c1_q;
      logic [7:0] c2_q;

      always_ff @(posedge clk) begin
         if (rst || clear_lines) begin
            c1_q <= SPACE_CHAR;
            c2_q <= SPACE_CHAR;
         end else begin
            if (wr_line1 && (wr_idx == IDX_W'(gi))) c1_q <= xfer_byte;
            if (wr_line2 && (wr_idx == IDX_W'(gi))) c2_q <= xfer_byte;
         end
      end

      assign line1[8*(LINE_CHARS-gi)-1 -: 8] = c1_q;
      assign line2[8*(LINE_CHARS-gi)-1 -: 8] = c2_q;
   end

   assign cursor_addr = addr_q;
   assign display_on  = disp_q;
   assign cmd_strobe  = cmd_stb_q;
   assign data_strobe = data_stb_q;
   assign proto_err   = err_q;

endmodule

// File: tb/tb_tlcd_bus_monitor.sv
// Directed bench for tlcd_bus_monitor; the 4-bit sequence runs when
// TLCD_MON_4BIT_EN is defined, otherwise the DL=0 error path is checked.
module tb_tlcd_bus_monitor;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   TLCD_D;
   logic         TLCD_E;
   logic         TLCD_RS;
   logic         TLCD_RW;
   logic [127:0] line1;
   logic [127:0] line2;
   logic [6:0]   cursor_addr;
   logic         display_on;
   logic         cmd_strobe;
   logic         data_strobe;
   logic         proto_err;

   int n_cmp = 0;
   int n_bad = 0;
   int ds_cnt = 0;
   int cs_cnt = 0;

   logic [127:0] spaces;
   logic [127:0] exp1;
   logic [127:0] exp2;

   typedef struct {
      logic       rs;
      logic [7:0] d;
      logic [6:0] addr;
      logic       disp;
      logic       err;
   } vec_t;

   vec_t vecs [17];

   always #5 clk = ~clk;

   tlcd_bus_monitor dut (
      .clk         (clk),
      .rst         (rst),
      .TLCD_D      (TLCD_D),
      .TLCD_E      (TLCD_E),
      .TLCD_RS     (TLCD_RS),
      .TLCD_RW     (TLCD_RW),
      .line1       (line1),
      .line2       (line2),
      .cursor_addr (cursor_addr),
      .display_on  (display_on),
      .cmd_strobe  (cmd_strobe),
      .data_strobe (data_strobe),
      .proto_err   (proto_err)
   );

   always @(negedge clk) begin
      if (data_strobe) ds_cnt++;
      if (cmd_strobe)  cs_cnt++;
   end

   task automatic chk_b(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_a(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_l(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // E high one cycle then low; returns at the falling-edge sample point
   task automatic pulse(input logic rs, input logic [7:0] d, input logic rw);
      @(negedge clk);
      TLCD_RS = rs;
      TLCD_RW = rw;
      TLCD_D  = d;
      TLCD_E  = 1'b1;
      @(negedge clk);
      TLCD_E  = 1'b0;
   endtask

   // Full transfer; returns in the cycle where outputs reflect it
   task automatic xfer(input logic rs, input logic [7:0] d, input logic rw = 1'b0);
      pulse(rs, d, rw);
      @(negedge clk);
      $display("xfer rs=%0d rw=%0d d=%h -> addr=%h cmd=%0d data=%0d err=%0d",
               rs, rw, d, cursor_addr, cmd_strobe, data_strobe, proto_err);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic set_char(inout logic [127:0] ln, input int idx, input logic [7:0] c);
      ln[127-8*idx -: 8] = c;
   endtask

   initial begin
      rst     = 1'b0;
      TLCD_D  = 8'h00;
      TLCD_E  = 1'b0;
      TLCD_RS = 1'b0;
      TLCD_RW = 1'b0;
      spaces  = {16{8'h20}};

      vecs[0]  = '{1'b0, 8'h01, 7'h00, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 8'h0C, 7'h00, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 8'h80, 7'h00, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, "M",   7'h01, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, "O",   7'h02, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, "N",   7'h03, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, "E",   7'h04, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, "Y",   7'h05, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 8'h06, 7'h05, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 8'h10, 7'h04, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 8'h14, 7'h05, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 8'h02, 7'h00, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 8'h08, 7'h00, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 8'h0C, 7'h00, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 8'h85, 7'h05, 1'b1, 1'b0};
      vecs[15] = '{1'b0, 8'h38, 7'h05, 1'b1, 1'b0};
      vecs[16] = '{1'b0, 8'h00, 7'h05, 1'b1, 1'b0};

      // Reset state
      do_reset();
      chk_l("rst_line1", line1, spaces);
      chk_l("rst_line2", line2, spaces);
      chk_a("rst_addr", cursor_addr, 7'h00);
      chk_b("rst_disp", display_on, 1'b0);
      chk_b("rst_cmd", cmd_strobe, 1'b0);
      chk_b("rst_data", data_strobe, 1'b0);
      chk_b("rst_err", proto_err, 1'b0);

      // Table: clear, display on, "MONEY", cursor moves, nop
      ds_cnt = 0;
      cs_cnt = 0;
      for (int i = 0; i < 17; i++) begin
         xfer(vecs[i].rs, vecs[i].d);
         chk_b($sformatf("v%0d_cmd", i), cmd_strobe, !vecs[i].rs);
         chk_b($sformatf("v%0d_data", i), data_strobe, vecs[i].rs);
         chk_a($sformatf("v%0d_addr", i), cursor_addr, vecs[i].addr);
         chk_b($sformatf("v%0d_disp", i), display_on, vecs[i].disp);
         chk_b($sformatf("v%0d_err", i), proto_err, vecs[i].err);
      end
      exp1 = {"MONEY", {11{8'h20}}};
      exp2 = spaces;
      chk_l("money_line1", line1, exp1);
      chk_l("money_line2", line2, exp2);
      #1;
      chk_i("money_ds_cnt", ds_cnt, 5);
      chk_i("money_cs_cnt", cs_cnt, 12);

      // Back-to-back data writes every 2 cycles at address 5
      @(negedge clk);
      TLCD_RS = 1'b1;
      TLCD_D  = "S";
      TLCD_E  = 1'b1;
      @(negedge clk);
      TLCD_E  = 1'b0;
      @(negedge clk);
      TLCD_D  = "T";
      TLCD_E  = 1'b1;
      chk_b("b2b_stb1", data_strobe, 1'b1);
      chk_a("b2b_addr1", cursor_addr, 7'h06);
      @(negedge clk);
      TLCD_E  = 1'b0;
      chk_b("b2b_gap", data_strobe, 1'b0);
      @(negedge clk);
      chk_b("b2b_stb2", data_strobe, 1'b1);
      chk_a("b2b_addr2", cursor_addr, 7'h07);
      set_char(exp1, 5, "S");
      set_char(exp1, 6, "T");
      chk_l("b2b_line1", line1, exp1);

      // Line 2 fill; 17th byte lands off-screen
      xfer(1'b0, 8'hC0);
      for (int i = 0; i < 16; i++) begin
         xfer(1'b1, 8'h61 + 8'(i));
         set_char(exp2, i, 8'h61 + 8'(i));
      end
      chk_l("l2_full", line2, exp2);
      chk_a("l2_addr", cursor_addr, 7'h50);
      xfer(1'b1, "Z");
      chk_b("l2_17_stb", data_strobe, 1'b1);
      chk_l("l2_17_line2", line2, exp2);
      chk_l("l2_17_line1", line1, exp1);
      chk_a("l2_17_addr", cursor_addr, 7'h51);

      // Wrap rules
      xfer(1'b0, 8'hA7);
      chk_a("wrap_set27", cursor_addr, 7'h27);
      xfer(1'b1, "Q");
      chk_a("wrap_27_40", cursor_addr, 7'h40);
      chk_l("wrap_q_line1", line1, exp1);
      chk_l("wrap_q_line2", line2, exp2);
      xfer(1'b0, 8'h10);
      chk_a("wrap_40_27", cursor_addr, 7'h27);
      xfer(1'b0, 8'h80);
      xfer(1'b0, 8'h04);
      xfer(1'b1, "X");
      set_char(exp1, 0, "X");
      chk_l("wrap_dec_line1", line1, exp1);
      chk_a("wrap_00_67", cursor_addr, 7'h67);
      xfer(1'b0, 8'h06);
      xfer(1'b1, "!");
      chk_a("wrap_67_00", cursor_addr, 7'h00);
      chk_l("wrap_67_line1", line1, exp1);
      chk_l("wrap_67_line2", line2, exp2);

      // CGRAM mode discards data until a DDRAM address is set
      xfer(1'b0, 8'h40);
      xfer(1'b1, "W");
      chk_l("cg_line1", line1, exp1);
      chk_a("cg_addr", cursor_addr, 7'h00);
      xfer(1'b0, 8'h80);
      xfer(1'b1, "K");
      set_char(exp1, 0, "K");
      chk_l("cg_exit_line1", line1, exp1);
      chk_a("cg_exit_addr", cursor_addr, 7'h01);

      // Read transfers are ignored
      xfer(1'b1, "R", 1'b1);
      chk_b("rd_data", data_strobe, 1'b0);
      chk_b("rd_cmd", cmd_strobe, 1'b0);
      chk_a("rd_addr", cursor_addr, 7'h01);
      chk_l("rd_line1", line1, exp1);
      chk_b("pre_err", proto_err, 1'b0);

      // Protocol errors are sticky
      xfer(1'b0, 8'h18);
      chk_b("err_shift", proto_err, 1'b1);
      chk_a("err_shift_addr", cursor_addr, 7'h01);
      xfer(1'b0, 8'hA8);
      chk_a("err_gap_addr", cursor_addr, 7'h28);
      xfer(1'b1, "E");
      chk_a("err_gap_step", cursor_addr, 7'h29);
      chk_l("err_line1", line1, exp1);
      chk_l("err_line2", line2, exp2);
      xfer(1'b0, 8'h80);
      chk_b("err_sticky", proto_err, 1'b1);

      // Reset while E is high after "AB"
      do_reset();
      chk_b("rst2_err", proto_err, 1'b0);
      xfer(1'b0, 8'h80);
      xfer(1'b1, "A");
      xfer(1'b1, "B");
      exp1 = {"AB", {14{8'h20}}};
      chk_l("ab_line1", line1, exp1);
      @(negedge clk);
      TLCD_RS = 1'b1;
      TLCD_D  = "C";
      TLCD_E  = 1'b1;
      rst     = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      TLCD_E  = 1'b0;
      @(negedge clk);
      chk_b("midrst_data", data_strobe, 1'b0);
      chk_b("midrst_cmd", cmd_strobe, 1'b0);
      chk_l("midrst_line1", line1, spaces);
      chk_a("midrst_addr", cursor_addr, 7'h00);
      @(negedge clk);
      chk_b("midrst_data2", data_strobe, 1'b0);

      // Function Set with DL=0
      exp1 = spaces;
`ifdef TLCD_MON_4BIT_EN
      xfer(1'b0, 8'h28);
      chk_b("fs4_err", proto_err, 1'b0);
      chk_b("fs4_cmd", cmd_strobe, 1'b1);
      xfer(1'b1, 8'h40);
      chk_b("nib1_data", data_strobe, 1'b0);
      chk_a("nib1_addr", cursor_addr, 7'h00);
      xfer(1'b1, 8'h10);
      chk_b("nib2_data", data_strobe, 1'b1);
      set_char(exp1, 0, "A");
      chk_l("nib2_line1", line1, exp1);
      chk_a("nib2_addr", cursor_addr, 7'h01);
      xfer(1'b0, 8'h40);
      xfer(1'b1, 8'h20);
      chk_b("nibmis_err", proto_err, 1'b1);
      chk_b("nibmis_data", data_strobe, 1'b0);
      chk_l("nibmis_line1", line1, exp1);
      xfer(1'b0, 8'h30);
      xfer(1'b0, 8'h80);
      chk_b("fs8_cmd", cmd_strobe, 1'b1);
      xfer(1'b1, "B");
      set_char(exp1, 1, "B");
      chk_l("back8_line1", line1, exp1);
      chk_a("back8_addr", cursor_addr, 7'h02);
`else
      xfer(1'b0, 8'h28);
      chk_b("dl0_err", proto_err, 1'b1);
      xfer(1'b1, "A");
      set_char(exp1, 0, "A");
      chk_b("dl0_data", data_strobe, 1'b1);
      chk_l("dl0_line1", line1, exp1);
      chk_a("dl0_addr", cursor_addr, 7'h01);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
